// File: rtl/imuldiv_div_requester.sv
// Initiator-side client for the iterative divider.
// Takes one divide command at a time from the pipeline, issues it to the divider
// over val/rdy, and returns a tagged quotient/remainder. Divide-by-zero is answered
// locally. A saturating timer aborts hung SEND/WAIT phases with an error response.
module imuldiv_div_requester #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_val,
    output logic             cmd_rdy,
    input  logic             cmd_fn,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    input  logic [63:0]      divresp_msg_result,
    output logic             rsp_val,
    input  logic             rsp_rdy,
    output logic [31:0]      rsp_quot,
    output logic [31:0]      rsp_rem,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    // Last timer value before the abort fires; the timer counts from 0 on SEND entry.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e             state_q;
    logic               fn_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        quot_q;
    logic [31:0]        rem_q;
    logic               err_q;
    logic               sticky_q;
    logic [7:0]         timer_q;
    logic [7:0]         timer_d;

    logic cmd_xfer;
    logic req_xfer;
    logic resp_xfer;
    logic rsp_xfer;
    logic timeout;

    // Handshake outputs decode state only, so no input reaches an output combinationally.
    assign cmd_rdy     = (state_q == IDLE);
    assign divreq_val  = (state_q == SEND);
    assign divresp_rdy = (state_q == WAIT);
    assign rsp_val     = (state_q == RESP);

    assign divreq_msg_fn = fn_q;
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;

    assign rsp_quot   = quot_q;
    assign rsp_rem    = rem_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;
    assign err_sticky = sticky_q;

    assign cmd_xfer  = cmd_val     && cmd_rdy;
    assign req_xfer  = divreq_val  && divreq_rdy;
    assign resp_xfer = divresp_val && divresp_rdy;
    assign rsp_xfer  = rsp_val     && rsp_rdy;

    // Saturate so a transaction that survives past the abort point cannot wrap back to it.
    assign timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    assign timeout = (timer_q == TMO_LAST);

    // Transaction FSM with its command, result and timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            fn_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_xfer) begin
                        fn_q    <= cmd_fn;
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        tag_q   <= cmd_tag;
                        timer_q <= '0;
                        if (cmd_b == 32'd0) begin
                            // Divide-by-zero answered locally, independent of signedness.
                            quot_q  <= 32'hFFFF_FFFF;
                            rem_q   <= cmd_a;
                            err_q   <= 1'b0;
                            state_q <= RESP;
                        end else begin
                            state_q <= SEND;
                        end
                    end
                end
                SEND: begin
                    timer_q <= timer_d;
                    if (req_xfer) begin
                        state_q <= WAIT;
                    end else if (timeout) begin
                        quot_q   <= '0;
                        rem_q    <= '0;
                        err_q    <= 1'b1;
                        sticky_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                WAIT: begin
                    timer_q <= timer_d;
                    if (resp_xfer) begin
                        quot_q  <= divresp_msg_result[31:0];
                        rem_q   <= divresp_msg_result[63:32];
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end else if (timeout) begin
                        quot_q   <= '0;
                        rem_q    <= '0;
                        err_q    <= 1'b1;
                        sticky_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    // Always return through IDLE so a new command never overlaps the rsp transfer.
                    if (rsp_xfer) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
